// File: rtl/misc_v_pkg.sv
// Shared constants and types for the fetch/decode slice: opcodes, instruction field
// positions and the fetch FSM state encoding.
package misc_v_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ITYPE = 3'd1;
  localparam logic [2:0] OP_LW    = 3'd2;
  localparam logic [2:0] OP_SW    = 3'd3;
  localparam logic [2:0] OP_BEQ   = 3'd4;
  localparam logic [2:0] OP_BNE   = 3'd5;
  localparam logic [2:0] OP_JIN   = 3'd6;
  localparam logic [2:0] OP_JOUT  = 3'd7;

  // opcode occupies the top OPCODE_W bits of the instruction; func sits at the bottom
  localparam int OPCODE_W = 3;
  localparam int FUNC_W   = 4;
  localparam int FUNC_LSB = 0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with redirect load and wrapping increment.
module fetch_pc_reg #(
  parameter int                PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int unsigned       PC_INC   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)        pc <= RESET_PC;
    else if (load)    pc <= target;
    else if (advance) pc <= pc + PC_W'(PC_INC);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response handshake, instruction register.
// Optional performance counters are compiled in with `define FETCH_PERF_CNT_EN.
module fetch_unit
  import misc_v_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [3:0]         func,
  output logic [PC_W-1:0]    instr_pc,
  output logic               bubble
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
  output logic [15:0]        kill_count
`endif
);

  fetch_state_e    state;
  logic            kill;
  logic [PC_W-1:0] pc;
  logic            pc_load;
  logic            rsp_take;
  logic            rsp_drop;

  // A redirect in any active state retargets the PC; IDLE lasts a single cycle and ignores it.
  assign pc_load  = redirect_valid && (state != IDLE);
  assign rsp_take = (state == WAIT) && imem_rsp_valid && !kill && !redirect_valid;
  assign rsp_drop = (state == WAIT) && imem_rsp_valid && (kill || redirect_valid);

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .target  (redirect_target),
    .advance (rsp_take),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      kill           <= 1'b0;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            kill           <= redirect_valid;
          end
        end
        WAIT: begin
          if (rsp_drop) begin
            kill           <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end else if (rsp_take) begin
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid || !stall) begin
            instr_valid    <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[INSTR_W-1 -: OPCODE_W];
  assign func      = instr[FUNC_LSB +: FUNC_W];
  assign bubble    = reset | ~instr_valid;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
      kill_count  <= '0;
    end else begin
      if (rsp_take && (fetch_count != '1)) fetch_count <= fetch_count + 32'd1;
      if ((state == HOLD) && stall && !redirect_valid && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (rsp_drop && (kill_count != '1)) kill_count <= kill_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request and response handshake.
- Holds the fetched instruction and presents opcode/func fields, plus a bubble signal that drives the decoder's reset input.
- Accepts branch/jump redirects from the execute side and discards any stale in-flight fetch.

Parameters:
- PC_W, 16, PC and instruction-address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 1, PC increment per instruction (word-addressed memory).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  PC_W  fetch address; stable while imem_req_valid=1.
- imem_rsp_valid  in  1  response data valid; exactly one per accepted request.
- imem_rsp_data  in  INSTR_W  fetched instruction.
- stall  in  1  downstream not ready; hold the current instruction.
- redirect_valid  in  1  branch/jump taken (one-cycle pulse).
- redirect_target  in  PC_W  new PC.
- instr_valid  out  1  instr holds a live instruction.
- instr  out  INSTR_W  held instruction.
- opcode  out  3  instr[INSTR_W-1 -: 3].
- func  out  4  instr[3:0].
- instr_pc  out  PC_W  address of the held instruction.
- bubble  out  1  reset | ~instr_valid; drives the decoder reset so an invalid slot issues no writes.

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, kill=0.
  - instr_valid=0, instr=0, instr_pc=0, imem_req_valid=0, bubble=1.
- Reset mid-operation aborts all states in one cycle. Any response arriving after reset is ignored until a new request is accepted.
- State IDLE: one cycle, then REQ.
- State REQ: imem_req_valid=1 and imem_addr=pc.
  - On imem_req_ready, go to WAIT.
  - On redirect_valid without ready, set pc=redirect_target and stay in REQ. The address changes the next cycle; this is the only permitted address change while valid is high.
  - On redirect_valid together with ready, set pc=target, kill=1, and go to WAIT.
- State WAIT: imem_req_valid=0.
  - On imem_rsp_valid with kill=1, or with redirect_valid in the same cycle: drop the data, set kill=0, and go to REQ. On redirect, pc=target.
  - On imem_rsp_valid with kill=0 and no redirect: instr=rsp_data, instr_pc=pc, pc=pc+PC_INC (mod 2^PC_W), instr_valid=1, go to HOLD.
  - On redirect_valid without a response: pc=target, kill=1, stay in WAIT.
- State HOLD: instr_valid=1; instr, opcode and func are stable.
  - redirect_valid has priority over stall: instr_valid=0, pc=target, go to REQ.
  - stall=1 with no redirect: hold everything.
  - stall=0: instruction consumed this cycle; instr_valid=0 next cycle, go to REQ.
- Latency and throughput:
  - Minimum 3 cycles per instruction: REQ, WAIT (0-wait memory answers one cycle after acceptance), HOLD.
  - First instr_valid rises 4 cycles after reset deasserts, with an always-ready, 1-cycle memory.
- PC wrap: 0xFFFF + 1 yields 0x0000, with no flag.
- opcode, func and bubble are combinational from the registers.
- instr is unchanged while instr_valid=0, but consumers must ignore it.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs fetch_count[31:0] (increments on each HOLD entry) and stall_count[31:0] (increments each cycle in HOLD with stall=1 and no redirect).
  - Adds output kill_count[15:0] (increments on each dropped response).
  - All three clear on reset and saturate at their maximum.
- Without it: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package misc_v_pkg:
  - Opcode constants OP_RTYPE=0, OP_ITYPE=1, OP_LW=2, OP_SW=3, OP_BEQ=4, OP_BNE=5, OP_JIN=6, OP_JOUT=7.
  - Field-position constants for opcode and func.
  - The fetch state enum (IDLE, REQ, WAIT, HOLD).
- Sub-module: fetch_pc_reg, holding the PC register plus the increment/redirect mux.
- The FSM and instruction register stay in fetch_unit.

Test Plan:
- Reset, then release with always-ready 1-cycle memory returning 0x2005 → addresses 0,1,2 in successive REQs; first instr_valid 4 cycles after release; opcode=1, func=5, instr_pc=0.
- Hold stall=1 for 5 cycles in HOLD → instr, opcode and func stable; no request issued; bubble=0; next request goes out 1 cycle after stall drops.
- Redirect to 0x0040 while in WAIT, with the response one cycle later → the response is dropped, instr_valid stays 0, the next imem_addr is 0x0040, and the first valid instr_pc is 0x0040.
- Redirect and imem_req_ready in the same REQ cycle → the accepted request's response is discarded and the next request is to the target.
- Redirect during HOLD with stall=1 → instr_valid falls the next cycle and the next fetch goes to the target.
- pc=0xFFFF fetched → next imem_addr=0x0000.
- Reset asserted in WAIT → instr_valid=0, pc=RESET_PC, bubble=1 the next cycle.
